// File: rtl/drive_pkg.sv
// Shared encodings for the manual, semi-auto and auto drive controllers.
//
// Contents:
//   POFF / PON      - power indication levels
//   run_state_e     - car run state (NSTART, START, MOVING, OFF)
//   moving_state_e  - moving sub-state, one-hot except NON_MOVING
package drive_pkg;

    localparam logic POFF = 1'b0;
    localparam logic PON  = 1'b1;

    typedef enum logic [1:0] {
        NSTART = 2'b00,
        START  = 2'b01,
        MOVING = 2'b10,
        OFF    = 2'b11
    } run_state_e;

    typedef enum logic [3:0] {
        NON_MOVING   = 4'b0000,
        MOVE_FORWARD = 4'b0001,
        MOVE_BACK    = 4'b0010,
        TURN_LEFT    = 4'b0100,
        TURN_RIGHT   = 4'b1000
    } moving_state_e;

endpackage

// File: rtl/turn_blinker.sv
// Turn / hazard lamp blinker.
//
// A free-running counter 0..BLINK_HALF-1 toggles a blink phase on every wrap.
// Each lamp is registered as its request ANDed with the phase value that is
// being loaded on the same edge, so lamps line up with the phase register.
//
// Ports:
//   clk    - system clock
//   rst_n  - synchronous active-low reset (counter 0, phase 1, lamps 0)
//   req_l  - left lamp request (from next-state values)
//   req_r  - right lamp request
//   lamp_l - left lamp drive (registered)
//   lamp_r - right lamp drive (registered)
module turn_blinker #(
    parameter int unsigned BLINK_HALF = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_l,
    input  logic req_r,
    output logic lamp_l,
    output logic lamp_r
);

    localparam int unsigned CntW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(BLINK_HALF - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            phase_q, phase_d;
    logic            lamp_l_q, lamp_r_q;

    always_comb begin
        cnt_d   = cnt_q + CntW'(1);
        phase_d = phase_q;
        if (cnt_q == CntMax) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            phase_q  <= 1'b1;
            lamp_l_q <= 1'b0;
            lamp_r_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            lamp_l_q <= req_l & phase_d;
            lamp_r_q <= req_r & phase_d;
        end
    end

    assign lamp_l = lamp_l_q;
    assign lamp_r = lamp_r_q;

endmodule

// File: rtl/manual_drive_ctrl.sv
// Registered manual-drive controller.
//
// Owns the run state and moving sub-state, drives blinking turn/hazard lamps,
// stalls on a reverse-gear change without clutch, latches OFF until power is
// toggled, and counts saturating mileage while MOVING.
//
// Ports:
//   clk, rst_n                 - clock, synchronous active-low reset
//   power                      - global power switch
//   global_state               - mode select; 2'b00 enables idle hazard lamps in NSTART
//   clutch, brake, throttle    - pedals
//   rgs                        - reverse gear
//   left, right                - turn switches
//   state                      - run state (registered)
//   moving_state               - moving sub-state (registered)
//   manual_power               - 1 when state != OFF
//   turn_left_light            - left lamp drive
//   turn_right_light           - right lamp drive
//   off_event                  - one-cycle pulse on each non-reset entry into OFF
//   mileage                    - saturating distance units
module manual_drive_ctrl
    import drive_pkg::*;
#(
    parameter int unsigned BLINK_HALF = 50000000,
    parameter int unsigned MILE_TICKS = 100000000,
    parameter int unsigned MILE_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              power,
    input  logic [1:0]        global_state,
    input  logic              clutch,
    input  logic              brake,
    input  logic              throttle,
    input  logic              rgs,
    input  logic              left,
    input  logic              right,
    output logic [1:0]        state,
    output logic [3:0]        moving_state,
    output logic              manual_power,
    output logic              turn_left_light,
    output logic              turn_right_light,
    output logic              off_event,
    output logic [MILE_W-1:0] mileage
);

    localparam int unsigned SubW = (MILE_TICKS > 1) ? $clog2(MILE_TICKS) : 1;
    localparam logic [SubW-1:0] SubMax = SubW'(MILE_TICKS - 1);

    run_state_e    state_q, state_d;
    moving_state_e mov_q, mov_d;
    moving_state_e dir_code;
    logic          manual_power_q, manual_power_d;
    logic          off_event_q, off_event_d;
    // Previous-cycle samples used for edge detection.
    logic          power_prev_q, rgs_prev_q;
    logic          power_rise, rgs_changed;
    logic          req_l, req_r;

    logic [SubW-1:0]   mile_sub_q, mile_sub_d;
    logic [MILE_W-1:0] mileage_q, mileage_d;

    assign power_rise  = power & ~power_prev_q;
    assign rgs_changed = rgs ^ rgs_prev_q;

    // Direction while driving; reverse gear overrides the turn switches.
    always_comb begin
        dir_code = MOVE_FORWARD;
        if (rgs) begin
            dir_code = MOVE_BACK;
        end else if (left && !right) begin
            dir_code = TURN_LEFT;
        end else if (right && !left) begin
            dir_code = TURN_RIGHT;
        end
    end

    // Run-state next-state logic; power loss overrides every state.
    always_comb begin
        state_d = state_q;
        mov_d   = NON_MOVING;
        if (!power) begin
            state_d = OFF;
        end else begin
            unique case (state_q)
                OFF: begin
                    // Held power never re-arms: a stall needs a power toggle.
                    if (power_rise) begin
                        state_d = NSTART;
                    end
                end
                NSTART: begin
                    if (!brake) begin
                        if (throttle && !clutch) begin
                            state_d = OFF;
                        end else if (throttle && clutch && !rgs) begin
                            state_d = START;
                        end
                    end
                end
                START: begin
                    if (brake) begin
                        state_d = NSTART;
                    end else if (throttle && !clutch) begin
                        state_d = MOVING;
                        mov_d   = dir_code;
                    end
                end
                MOVING: begin
                    if (rgs_changed && !clutch) begin
                        state_d = OFF;
                    end else if (brake) begin
                        state_d = NSTART;
                    end else if (!throttle) begin
                        state_d = START;
                    end else begin
                        mov_d = dir_code;
                    end
                end
                default: state_d = OFF;
            endcase
        end
    end

    always_comb begin
        manual_power_d = (state_d != OFF) ? PON : POFF;
        off_event_d    = (state_d == OFF) && (state_q != OFF);
    end

    // Lamp requests follow the next state so lamps change with the state.
    always_comb begin
        req_l = 1'b0;
        req_r = 1'b0;
        unique case (state_d)
            NSTART: begin
                req_l = (global_state == 2'b00);
                req_r = (global_state == 2'b00);
            end
            START, MOVING: begin
                req_l = left & ~rgs;
                req_r = right & ~rgs;
            end
            default: begin
                req_l = 1'b0;
                req_r = 1'b0;
            end
        endcase
    end

    // Sub-counter holds outside MOVING; mileage saturates but the sub-counter keeps wrapping.
    always_comb begin
        mile_sub_d = mile_sub_q;
        mileage_d  = mileage_q;
        if (state_q == MOVING) begin
            if (mile_sub_q == SubMax) begin
                mile_sub_d = '0;
                if (mileage_q != {MILE_W{1'b1}}) begin
                    mileage_d = mileage_q + MILE_W'(1);
                end
            end else begin
                mile_sub_d = mile_sub_q + SubW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= OFF;
            mov_q          <= NON_MOVING;
            manual_power_q <= POFF;
            off_event_q    <= 1'b0;
            power_prev_q   <= 1'b0;
            rgs_prev_q     <= 1'b0;
            mile_sub_q     <= '0;
            mileage_q      <= '0;
        end else begin
            state_q        <= state_d;
            mov_q          <= mov_d;
            manual_power_q <= manual_power_d;
            off_event_q    <= off_event_d;
            power_prev_q   <= power;
            rgs_prev_q     <= rgs;
            mile_sub_q     <= mile_sub_d;
            mileage_q      <= mileage_d;
        end
    end

    turn_blinker #(
        .BLINK_HALF(BLINK_HALF)
    ) u_blinker (
        .clk   (clk),
        .rst_n (rst_n),
        .req_l (req_l),
        .req_r (req_r),
        .lamp_l(turn_left_light),
        .lamp_r(turn_right_light)
    );

    assign state        = state_q;
    assign moving_state = mov_q;
    assign manual_power = manual_power_q;
    assign off_event    = off_event_q;
    assign mileage      = mileage_q;

endmodule

// File: doc/manual_drive_ctrl.md
Name: manual_drive_ctrl

Overview:
- Registered, parametrised successor to the team's combinational manual-drive decoder.
- Owns the car run state and moving sub-state internally, instead of taking them from an external register.
- Adds blinking turn/hazard lights, edge-detected reverse-gear stall, power-off latching and a saturating mileage counter.
- Sits between the debounced switch inputs and the motor/display drivers, in parallel with the semi-auto and auto controllers selected by global_state.

Parameters:
BLINK_HALF, 50000000, clock cycles per half blink period (lamp on-time = off-time); must be >= 1.
MILE_TICKS, 100000000, MOVING cycles per mileage unit; must be >= 1.
MILE_W, 16, width of the mileage output.

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst_n  in  1  reset, synchronous, active-low.
power  in  1  global power switch.
global_state  in  2  mode select; 2'b00 = manual-idle indication.
clutch, brake, throttle, rgs, left, right  in  1 each  driver controls (rgs = reverse gear).
state  out  2  run state: NSTART=00, START=01, MOVING=10, OFF=11.
moving_state  out  4  NON_MOVING=0000, MOVE_FORWARD=0001, MOVE_BACK=0010, TURN_LEFT=0100, TURN_RIGHT=1000.
manual_power  out  1  1 when state != OFF.
turn_left_light, turn_right_light  out  1 each  lamp drives.
off_event  out  1  one-cycle pulse on every entry into OFF, except the entry caused by rst_n.
mileage  out  MILE_W  distance units travelled; saturating.

Behaviour:
- Reset (rst_n=0 at a clk edge) sets these registers:
  - state=OFF, moving_state=0000, manual_power=0, both lights 0, off_event=0.
  - mileage=0, mile sub-counter=0, blink counter=0, blink phase=1.
  - power_d=0, rgs_d=0.
- Latency: every output is registered and reflects the inputs sampled at the previous edge.
- Any state, power=0: next state OFF, moving NON_MOVING. This has highest priority after reset.
- OFF: go to NSTART only on a power rising edge (power=1, power_d=0). power held high never re-arms, so a manual stall needs a power toggle.
- NSTART, first matching rule wins:
  1. brake: stay.
  2. throttle & ~clutch: OFF (stall).
  3. throttle & clutch & ~rgs: START.
  4. otherwise: stay.
  - moving_state is NON_MOVING throughout.
- START, first matching rule wins:
  1. brake: NSTART.
  2. throttle & ~clutch: MOVING, with moving_state = rgs ? MOVE_BACK : dir.
  3. otherwise: stay, NON_MOVING.
- MOVING, first matching rule wins:
  1. rgs changed (rgs != rgs_d) & ~clutch: OFF.
  2. brake: NSTART.
  3. ~throttle: START.
  4. otherwise: stay, with moving_state = rgs ? MOVE_BACK : dir.
- dir: left&~right gives TURN_LEFT; right&~left gives TURN_RIGHT; neither or both gives MOVE_FORWARD.
- rgs_d and power_d are sampled every cycle.
- Blink timing:
  - The blink counter is free-running 0..BLINK_HALF-1.
  - The phase toggles when the counter wraps.
  - Lamp = request & phase.
- Light requests:
  - OFF: none.
  - NSTART: both lamps requested iff global_state==00.
  - START/MOVING with rgs=0: left lamp if left, right lamp if right; both pressed gives hazards.
  - START/MOVING with rgs=1: none.
  - Requests are computed from next-state values, so lamps align with state.
- Mileage:
  - The sub-counter increments on each cycle whose registered state is MOVING.
  - It holds (does not clear) outside MOVING.
  - At MILE_TICKS-1 it wraps to 0 and mileage increments.
  - mileage saturates at 2^MILE_W-1, and the sub-counter keeps wrapping.
  - Mileage survives OFF; only rst_n clears it.
- Simultaneous events: brake beats throttle in every state; the rgs-toggle stall beats brake in MOVING; power=0 beats everything.

Decomposition:
- Shared package drive_pkg holds the state and moving_state encodings (POFF/PON, NSTART/START/MOVING/OFF, the five moving codes). The semi-auto and auto controllers use the same package.
- One sub-module, turn_blinker (param BLINK_HALF; clk, rst_n, req_l, req_r → lamp_l, lamp_r), contains the counter and phase.
- Mileage logic stays inline.

Test Plan:
All scenarios use BLINK_HALF=4, MILE_TICKS=10, MILE_W=4.
1. Hold rst_n=0 for 2 edges with power=1, global_state=00, then release. Required: state=00, manual_power=1 one edge later; both lamps toggle every 4 cycles.
2. In NSTART, throttle=1, clutch=0. Required: next edge state=11, manual_power=0, off_event=1 for exactly one cycle. Holding power=1 keeps OFF. Setting power 0 then 1 gives state=00.
3. From NSTART, clutch=1, throttle=1 gives START. Then clutch=0 gives MOVING with moving_state=0001. Then left=1 gives 0100 and turn_left_light with period 8, turn_right_light=0.
4. Hold MOVING for 25 cycles: mileage=2. Hold for 200 more: mileage=15 (saturated, no wrap).
5. In MOVING with clutch=1, raise rgs: moving_state=0010, both lamps 0. Then clutch=0 and drop rgs: next edge state=11, off_event pulse.
6. In MOVING, apply brake=1 and throttle=1 together: state=00. Then pull rst_n=0 mid-MOVING: state=11, mileage=0, off_event=0.
